core_cyc_ctl: RTL and testbench
===============================

CORE_CYC_CTL -- requirements
Module: core_cyc_ctl

Interface
REQ-001 SHALL have clk, input, 1, system clock; one tick = 10 ns.
REQ-002 SHALL have reset, input, 1, asynchronous, active-high.
REQ-003 SHALL have req0 / req1, input, 1 each, level memory-cycle request from requester 0 / 1.
REQ-004 SHALL have wr0 / wr1, input, 1 each, write-only cycle flag for requester 0 / 1; sampled with its req at grant.
REQ-005 SHALL have inhibit, input, 1, level; blocks new grants.
REQ-006 SHALL have ack0 / ack1, output, 1 each, level; high while that requester owns the cycle.
REQ-007 SHALL have busy, output, 1; high whenever a cycle is in progress.
REQ-008 SHALL have rd_p, strb_p, rs_p, wr_p and done_p, each output, 1, one-clock pulses: read, sense strobe, read-data-ready, write/restore and cycle end.

Function
REQ-009 SHALL implement two states: IDLE and CYC; CYC contains an 8-bit tick counter cnt.
REQ-010 In IDLE with inhibit low and any req high, the controller SHALL, on the next clock edge: enter CYC, clear cnt to 0, latch the granted requester into sel, and latch that requester's wr into wl.
REQ-011 Arbitration SHALL be round-robin.
- Single requester: granted.
- Both requesting: the requester not in register last is granted.
- last SHALL update to the granted requester at grant.
REQ-012 In IDLE with inhibit high, the controller SHALL grant nothing; requests SHALL be held off and not lost, since they are levels.
REQ-013 In CYC, cnt SHALL increment by 1 every clock.
REQ-014 Pulse decode in CYC SHALL be:
- rd_p at cnt==0, unconditional.
- strb_p at cnt==40, only if wl==0.
- rs_p at cnt==41, only if wl==0; rs_p at cnt==1 if wl==1 (write data accept).
- wr_p at cnt==100.
- done_p at cnt==150.
REQ-015 On the edge following cnt==150, the controller SHALL return to IDLE and drop ack.
- A new grant is possible on the next edge, so the minimum cycle-to-cycle spacing is 152 clocks.
REQ-016 Each pulse SHALL be exactly one clock wide and SHALL be decoded only from registered state; no input SHALL reach a pulse output combinationally.
REQ-017 ack0 SHALL equal (state==CYC && sel==0), ack1 SHALL equal (state==CYC && sel==1), and busy SHALL equal (state==CYC).
REQ-018 Once granted, a cycle SHALL always run to done_p; req deassertion, wr change or inhibit during CYC SHALL have no effect.
REQ-019 Requests arriving during CYC SHALL be ignored until IDLE.
REQ-020 cnt SHALL never exceed 150 and SHALL not wrap.

Reset
REQ-021 While reset is high, the block SHALL hold: state=IDLE, cnt=0, sel=0, wl=0 and last=1, with all outputs 0.
REQ-022 Reset asserted mid-cycle SHALL abort the cycle immediately, with no further pulses.
REQ-023 After reset deasserts, the first grant SHALL go to req0 if both requesters are active.

Verification
REQ-024 req0=1, wr0=0 held -> ack0 rises 1 clock later.
- rd_p at grant+0, strb_p at +40, rs_p at +41, wr_p at +100, done_p at +150.
- ack0 falls at +151; the next rd_p occurs at +152.
REQ-025 req1=1, wr1=1 single pulse of 1 clock -> full cycle.
- rs_p at +1, no strb_p, wr_p at +100, done_p at +150.
REQ-026 req0 and req1 both held high after reset -> grants alternate 0,1,0,1.
- ack0 and ack1 are never high together.
- Each cycle is 151 clocks long, with gaps of 1 clock.
REQ-027 inhibit=1 with req0=1 for 20 clocks -> no ack and no pulses.
- inhibit drops -> ack0 rises on the next edge.
REQ-028 reset pulsed at cnt==60 of a read cycle -> all outputs 0 immediately.
- No wr_p or done_p follows.
- With req1 and req0 both held, the next grant goes to req0.
REQ-029 Across a 10-cycle random-request run, the bench SHALL check:
- every pulse is 1 clock wide;
- rd_p count equals done_p count;
- strb_p count equals the number of read cycles.

Source files
------------

// File: rtl/core_cyc_ctl_if.sv
// Memory-cycle controller bus: requester handshakes,
// ownership/busy status and timing pulses.
interface core_cyc_ctl_if;
    logic req0;
    logic req1;
    logic wr0;
    logic wr1;
    logic inhibit;
    logic ack0;
    logic ack1;
    logic busy;
    logic rd_p;
    logic strb_p;
    logic rs_p;
    logic wr_p;
    logic done_p;

    modport master (
        output req0, req1, wr0, wr1, inhibit,
        input  ack0, ack1, busy,
        input  rd_p, strb_p, rs_p, wr_p, done_p
    );

    modport slave (
        input  req0, req1, wr0, wr1, inhibit,
        output ack0, ack1, busy,
        output rd_p, strb_p, rs_p, wr_p, done_p
    );
endinterface

// File: rtl/core_cyc_ctl.sv
// Two-requester memory-cycle controller: round-robin grant,
// then a fixed 151-clock timing sequence of one-clock pulses.
module core_cyc_ctl (
    input  logic           clk,
    input  logic           reset,
    core_cyc_ctl_if.slave  bus
);
    typedef enum logic {IDLE, CYC} state_t;

    localparam logic [7:0] T_RD   = 8'd0;
    localparam logic [7:0] T_WACC = 8'd1;
    localparam logic [7:0] T_STRB = 8'd40;
    localparam logic [7:0] T_RS   = 8'd41;
    localparam logic [7:0] T_WR   = 8'd100;
    localparam logic [7:0] T_DONE = 8'd150;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       wl_q, wl_d;
    logic       last_q, last_d;
    logic       gnt;

    // State register; last=1 so req0 wins the first contested grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            wl_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wl_q    <= wl_d;
            last_q  <= last_d;
        end
    end

    // Next state: arbitrate in IDLE, count through the cycle in CYC
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wl_d    = wl_q;
        last_d  = last_q;
        gnt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!bus.inhibit && (bus.req0 || bus.req1)) begin
                    if (bus.req0 && bus.req1) gnt = ~last_q;
                    else                      gnt = bus.req1;
                    state_d = CYC;
                    cnt_d   = 8'd0;
                    sel_d   = gnt;
                    wl_d    = gnt ? bus.wr1 : bus.wr0;
                    last_d  = gnt;
                end
            end
            CYC: begin
                if (cnt_q == T_DONE) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        bus.busy   = (state_q == CYC);
        bus.ack0   = (state_q == CYC) && !sel_q;
        bus.ack1   = (state_q == CYC) &&  sel_q;
        bus.rd_p   = (state_q == CYC) && (cnt_q == T_RD);
        bus.strb_p = (state_q == CYC) && !wl_q && (cnt_q == T_STRB);
        bus.rs_p   = (state_q == CYC) &&
                     (wl_q ? (cnt_q == T_WACC) : (cnt_q == T_RS));
        bus.wr_p   = (state_q == CYC) && (cnt_q == T_WR);
        bus.done_p = (state_q == CYC) && (cnt_q == T_DONE);
    end
endmodule

// File: tb/tb_core_cyc_ctl.sv
// Directed bench for core_cyc_ctl: pulse timing, arbitration,
// inhibit, mid-cycle reset and a random-request run.
module tb_core_cyc_ctl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    int   q_rd[$];
    int   q_strb[$];
    int   q_rs[$];
    int   q_wr[$];
    int   q_done[$];
    bit   ack0_tr[$];
    bit   ack1_tr[$];
    int   both_hi;

    core_cyc_ctl_if bus ();

    core_cyc_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {bus.ack0, bus.ack1, bus.busy, bus.rd_p,
                bus.strb_p, bus.rs_p, bus.wr_p, bus.done_p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample k=0..n-1 at post-edge points, recording pulse positions
    task automatic capture(input int n);
        q_rd.delete();
        q_strb.delete();
        q_rs.delete();
        q_wr.delete();
        q_done.delete();
        ack0_tr.delete();
        ack1_tr.delete();
        both_hi = 0;
        for (int k = 0; k < n; k++) begin
            if (bus.rd_p)   q_rd.push_back(k);
            if (bus.strb_p) q_strb.push_back(k);
            if (bus.rs_p)   q_rs.push_back(k);
            if (bus.wr_p)   q_wr.push_back(k);
            if (bus.done_p) q_done.push_back(k);
            ack0_tr.push_back(bus.ack0);
            ack1_tr.push_back(bus.ack1);
            if (bus.ack0 && bus.ack1) both_hi++;
            step();
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL %s idle timeout busy=%0b required 0", name, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.wr0 = 1'b0;
        bus.wr1 = 1'b0;
        bus.inhibit = 1'b0;
        #2;
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs got %b required 00000000", outs());
        end
        step();
        step();
        step();
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got %b required 00000000", outs());
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        reset = 1'b0;
        step();
        step();
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle got %b required 00000000", outs());
        end
    endtask

    task automatic test_read();
        bus.req0 = 1'b1;
        bus.wr0 = 1'b0;
        step();
        capture(153);
        bus.req0 = 1'b0;
        checks++;
        if (q_rd.size() != 2 || q_rd[0] != 0 || q_rd[1] != 152) begin
            errors++;
            $display("FAIL read_rd got %p required 0,152", q_rd);
        end
        checks++;
        if (q_strb.size() != 1 || q_strb[0] != 40) begin
            errors++;
            $display("FAIL read_strb got %p required 40", q_strb);
        end
        checks++;
        if (q_rs.size() != 1 || q_rs[0] != 41) begin
            errors++;
            $display("FAIL read_rs got %p required 41", q_rs);
        end
        checks++;
        if (q_wr.size() != 1 || q_wr[0] != 100) begin
            errors++;
            $display("FAIL read_wr got %p required 100", q_wr);
        end
        checks++;
        if (q_done.size() != 1 || q_done[0] != 150) begin
            errors++;
            $display("FAIL read_done got %p required 150", q_done);
        end
        checks++;
        if ({ack0_tr[0], ack0_tr[150], ack0_tr[151], ack0_tr[152]} !== 4'b1101) begin
            errors++;
            $display("FAIL read_ack0 got %b%b%b%b required 1101",
                     ack0_tr[0], ack0_tr[150], ack0_tr[151], ack0_tr[152]);
        end
        wait_idle("read");
    endtask

    task automatic test_write();
        int a0;
        int a1;
        bus.req1 = 1'b1;
        bus.wr1 = 1'b1;
        step();
        bus.req1 = 1'b0;
        bus.wr1 = 1'b0;
        capture(152);
        a0 = 0;
        a1 = 0;
        foreach (ack0_tr[i]) a0 += int'(ack0_tr[i]);
        foreach (ack1_tr[i]) a1 += int'(ack1_tr[i]);
        checks++;
        if (q_rd.size() != 1 || q_rd[0] != 0) begin
            errors++;
            $display("FAIL write_rd got %p required 0", q_rd);
        end
        checks++;
        if (q_strb.size() != 0) begin
            errors++;
            $display("FAIL write_strb got %p required none", q_strb);
        end
        checks++;
        if (q_rs.size() != 1 || q_rs[0] != 1) begin
            errors++;
            $display("FAIL write_rs got %p required 1", q_rs);
        end
        checks++;
        if (q_wr.size() != 1 || q_wr[0] != 100 ||
            q_done.size() != 1 || q_done[0] != 150) begin
            errors++;
            $display("FAIL write_wr_done got wr %p done %p required 100 150", q_wr, q_done);
        end
        checks++;
        if (a1 != 151 || a0 != 0 || ack1_tr[151]) begin
            errors++;
            $display("FAIL write_ack got ack1 %0d ack0 %0d required 151 0", a1, a0);
        end
    endtask

    task automatic test_inhibit();
        bus.inhibit = 1'b1;
        bus.req0 = 1'b1;
        bus.wr0 = 1'b0;
        capture(20);
        checks++;
        if (q_rd.size() + q_strb.size() + q_rs.size() + q_wr.size() +
            q_done.size() != 0 || ack0_tr.sum() != 0 || ack1_tr.sum() != 0) begin
            errors++;
            $display("FAIL inhibit_hold got rd %p ack0/1 activity required none", q_rd);
        end
        bus.inhibit = 1'b0;
        step();
        checks++;
        if ({bus.ack0, bus.rd_p} !== 2'b11) begin
            errors++;
            $display("FAIL inhibit_release got ack0,rd %b%b required 11", bus.ack0, bus.rd_p);
        end
        bus.req0 = 1'b0;
        wait_idle("inhibit");
    endtask

    task automatic test_alternate();
        int gap_bad;
        int busy_n;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.wr0 = 1'b0;
        bus.wr1 = 1'b0;
        step();
        capture(608);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if (q_rd.size() != 4 || q_rd[0] != 0 || q_rd[1] != 152 ||
            q_rd[2] != 304 || q_rd[3] != 456) begin
            errors++;
            $display("FAIL alt_rd got %p required 0,152,304,456", q_rd);
        end
        checks++;
        if ({ack0_tr[0], ack1_tr[152], ack0_tr[304], ack1_tr[456]} !== 4'b1111) begin
            errors++;
            $display("FAIL alt_order got %b%b%b%b required 1111",
                     ack0_tr[0], ack1_tr[152], ack0_tr[304], ack1_tr[456]);
        end
        checks++;
        if (both_hi != 0) begin
            errors++;
            $display("FAIL alt_overlap got %0d required 0", both_hi);
        end
        gap_bad = 0;
        busy_n = 0;
        foreach (ack0_tr[i]) begin
            if (ack0_tr[i] || ack1_tr[i]) busy_n++;
            else if (i != 151 && i != 303 && i != 455 && i != 607) gap_bad++;
        end
        checks++;
        if (busy_n != 604 || gap_bad != 0) begin
            errors++;
            $display("FAIL alt_gaps got busy %0d stray gaps %0d required 604 0",
                     busy_n, gap_bad);
        end
        wait_idle("alt");
    endtask

    task automatic test_reset_mid();
        bus.req0 = 1'b1;
        bus.wr0 = 1'b0;
        step();
        bus.req0 = 1'b0;
        for (int i = 0; i < 60; i++) step();
        checks++;
        if (bus.ack0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got ack0 %b required 1", bus.ack0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 8'h00) begin
            errors++;
            $display("FAIL mid_abort got %b required 00000000", outs());
        end
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        step();
        step();
        reset = 1'b0;
        capture(100);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if (q_rd.size() != 1 || q_rd[0] != 1 || ack0_tr[1] !== 1'b1 ||
            ack1_tr.sum() != 0) begin
            errors++;
            $display("FAIL mid_regrant got rd %p ack0 %b required 1 1", q_rd, ack0_tr[1]);
        end
        checks++;
        if (q_wr.size() != 0 || q_done.size() != 0) begin
            errors++;
            $display("FAIL mid_nopulse got wr %p done %p required none", q_wr, q_done);
        end
        wait_idle("mid");
    endtask

    task automatic test_random();
        int  n;
        int  rds;
        int  dones;
        int  strbs;
        int  reads;
        int  wide;
        int  both;
        bit  pw0;
        bit  pw1;
        logic [4:0] prv;
        logic [4:0] cur;
        n = 0;
        rds = 0;
        dones = 0;
        strbs = 0;
        reads = 0;
        wide = 0;
        both = 0;
        pw0 = 1'b0;
        pw1 = 1'b0;
        prv = 5'b0;
        while ((rds < 10 || bus.busy) && n < 4000) begin
            cur = {bus.rd_p, bus.strb_p, bus.rs_p, bus.wr_p, bus.done_p};
            if ((cur & prv) != 5'b0) wide++;
            prv = cur;
            if (bus.ack0 && bus.ack1) both++;
            if (bus.rd_p) begin
                rds++;
                if (bus.ack0 ? !pw0 : !pw1) reads++;
            end
            if (bus.done_p) dones++;
            if (bus.strb_p) strbs++;
            if (rds < 10) begin
                bus.req0 = 1'($urandom_range(0, 1));
                bus.req1 = 1'($urandom_range(0, 1));
                bus.wr0  = 1'($urandom_range(0, 1));
                bus.wr1  = 1'($urandom_range(0, 1));
            end else begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            pw0 = bus.wr0;
            pw1 = bus.wr1;
            step();
            n++;
        end
        checks++;
        if (n >= 4000 || rds != 10) begin
            errors++;
            $display("FAIL rand_timeout got cycles %0d rd %0d required <4000 10", n, rds);
        end
        checks++;
        if (wide != 0 || both != 0) begin
            errors++;
            $display("FAIL rand_width got wide %0d overlap %0d required 0 0", wide, both);
        end
        checks++;
        if (rds != dones) begin
            errors++;
            $display("FAIL rand_rd_done got rd %0d done %0d required equal", rds, dones);
        end
        checks++;
        if (strbs != reads) begin
            errors++;
            $display("FAIL rand_strb got strb %0d required %0d", strbs, reads);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_inhibit();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
